// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix multiplier datapath blocks.
package matrix_pkg;

  localparam int unsigned DefaultW = 32;
  localparam int unsigned IdxMaxW  = 8;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    StCollect,
    StDrain,
    StDone
  } state_e;

  typedef struct packed {
    logic [IdxMaxW-1:0] i;
    logic [IdxMaxW-1:0] j;
  } idx_pair_t;

endpackage

// File: rtl/matrix_index_counter.sv
// 2-D wrapping (i,j) counter; col_major makes i the inner index.
module matrix_index_counter
  import matrix_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = idx_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  input  logic             col_major,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic             last
);

  localparam logic [IDX_W-1:0] Max = IDX_W'(N - 1);

  logic [IDX_W-1:0] i_q, i_d, j_q, j_d;

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    if (clear) begin
      i_d = '0;
      j_d = '0;
    end else if (advance) begin
      if (col_major) begin
        if (i_q == Max) begin
          i_d = '0;
          j_d = (j_q == Max) ? '0 : j_q + IDX_W'(1);
        end else begin
          i_d = i_q + IDX_W'(1);
        end
      end else begin
        if (j_q == Max) begin
          j_d = '0;
          i_d = (i_q == Max) ? '0 : i_q + IDX_W'(1);
        end else begin
          j_d = j_q + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q <= '0;
      j_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

  assign i    = i_q;
  assign j    = j_q;
  assign last = (i_q == Max) && (j_q == Max);

endmodule

// File: rtl/result_matrix_collector.sv
// Collects multiplier results into an NxN buffer, then drains it as a stream.
// Define COLLECTOR_TRANSPOSE_EN for column-major drain order.
module result_matrix_collector
  import matrix_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = DefaultW,
  parameter int unsigned IDX_W = idx_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             z_stb,
  input  logic [W-1:0]     z_out,
  input  logic [IDX_W-1:0] z_i,
  input  logic [IDX_W-1:0] z_j,
  output logic             z_ack,
  output logic [W-1:0]     current_element,
  input  logic             mult_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [IDX_W-1:0] out_i,
  output logic [IDX_W-1:0] out_j,
  output logic             out_last,
  output logic             done,
  output logic             incomplete,
  output logic             late_write
);

`ifdef COLLECTOR_TRANSPOSE_EN
  localparam logic ColMajor = 1'b1;
`else
  localparam logic ColMajor = 1'b0;
`endif

  logic [W-1:0] mem [N][N];
  logic [N-1:0][N-1:0] written_q, written_d;

  state_e state_q, state_d;
  logic z_ack_q, z_ack_d;
  logic out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0] out_i_q, out_i_d, out_j_q, out_j_d;
  logic out_last_q, out_last_d;
  logic done_q, done_d;
  logic incomplete_q, incomplete_d;
  logic late_write_q, late_write_d;

  logic [IDX_W-1:0] cnt_i, cnt_j;
  logic cnt_last;
  logic [W-1:0] rd_data;
  logic accept, go_drain, beat, load;

  assign accept   = !clear && (state_q == StCollect) && z_stb && !z_ack_q;
  assign go_drain = !clear && (state_q == StCollect) && mult_done && !accept;
  assign beat     = (state_q == StDrain) && out_valid_q && out_ready;
  // The counter always points one element ahead of the output register.
  assign load     = go_drain || (!clear && beat && !out_last_q);

  matrix_index_counter #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_drain_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .advance   (load),
    .col_major (ColMajor),
    .i         (cnt_i),
    .j         (cnt_j),
    .last      (cnt_last)
  );

  assign rd_data         = written_q[cnt_i][cnt_j] ? mem[cnt_i][cnt_j] : '0;
  assign current_element = written_q[z_i][z_j] ? mem[z_i][z_j] : '0;

  // Buffer is intentionally unreset; the written bitmap masks stale contents.
  always_ff @(posedge clk) begin
    if (accept) mem[z_i][z_j] <= z_out;
  end

  always_comb begin
    state_d      = state_q;
    written_d    = written_q;
    z_ack_d      = 1'b0;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_i_d      = out_i_q;
    out_j_d      = out_j_q;
    out_last_d   = out_last_q;
    done_d       = done_q;
    incomplete_d = incomplete_q;
    late_write_d = late_write_q;

    if (clear) begin
      state_d      = StCollect;
      written_d    = '0;
      out_valid_d  = 1'b0;
      out_last_d   = 1'b0;
      done_d       = 1'b0;
      incomplete_d = 1'b0;
      late_write_d = 1'b0;
    end else begin
      case (state_q)
        StCollect: begin
          if (accept) begin
            written_d[z_i][z_j] = 1'b1;
            z_ack_d             = 1'b1;
          end else if (mult_done) begin
            state_d      = StDrain;
            incomplete_d = ~&written_q;
          end
        end
        StDrain: begin
          if (z_stb) late_write_d = 1'b1;
          if (beat && out_last_q) begin
            state_d     = StDone;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
          end
        end
        StDone: begin
          if (z_stb) late_write_d = 1'b1;
        end
        default: state_d = StCollect;
      endcase

      if (load) begin
        out_valid_d = 1'b1;
        out_data_d  = rd_data;
        out_i_d     = cnt_i;
        out_j_d     = cnt_j;
        out_last_d  = cnt_last;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StCollect;
      written_q    <= '0;
      z_ack_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_i_q      <= '0;
      out_j_q      <= '0;
      out_last_q   <= 1'b0;
      done_q       <= 1'b0;
      incomplete_q <= 1'b0;
      late_write_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      written_q    <= written_d;
      z_ack_q      <= z_ack_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_i_q      <= out_i_d;
      out_j_q      <= out_j_d;
      out_last_q   <= out_last_d;
      done_q       <= done_d;
      incomplete_q <= incomplete_d;
      late_write_q <= late_write_d;
    end
  end

  assign z_ack      = z_ack_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_i      = out_i_q;
  assign out_j      = out_j_q;
  assign out_last   = out_last_q;
  assign done       = done_q;
  assign incomplete = incomplete_q;
  assign late_write = late_write_q;

endmodule

// File: tb/tb_result_matrix_collector.sv
// Scoreboard bench for result_matrix_collector (N=4, W=32).
module tb_result_matrix_collector;

  logic        clk = 1'b0;
  logic        rst, clear, z_stb, mult_done, out_ready;
  logic [31:0] z_out;
  logic [1:0]  z_i, z_j;
  logic        z_ack, out_valid, out_last, done, incomplete, late_write;
  logic [31:0] current_element, out_data;
  logic [1:0]  out_i, out_j;

  result_matrix_collector #(.N(4), .W(32), .IDX_W(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .clear           (clear),
    .z_stb           (z_stb),
    .z_out           (z_out),
    .z_i             (z_i),
    .z_j             (z_j),
    .z_ack           (z_ack),
    .current_element (current_element),
    .mult_done       (mult_done),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_i           (out_i),
    .out_j           (out_j),
    .out_last        (out_last),
    .done            (done),
    .incomplete      (incomplete),
    .late_write      (late_write)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    int          i;
    int          j;
    bit          last;
  } beat_t;

  beat_t       sb_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          ack_cnt = 0;
  logic [31:0] mdl_mem [16];
  bit          mdl_wr [16];
  bit          toggle_en = 1'b0;
  bit [3:0]    pat = 4'b1001;
  int          tk = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ready pattern 1,0,0,1 repeating.
  always @(posedge clk) begin
    #1;
    if (toggle_en) begin
      out_ready = pat[tk % 4];
      tk++;
    end
  end

  always @(negedge clk) if (z_ack) ack_cnt++;

  // Monitor: pops expected beat on each handshake, and checks hold-stability across stalls.
  bit          stall_prev = 1'b0;
  logic [31:0] held_d;
  logic [1:0]  held_i, held_j;
  logic        held_l;
  always @(negedge clk) begin
    beat_t e;
    if (stall_prev && out_valid) begin
      check("stall_data", out_data, held_d);
      check("stall_idx", {out_i, out_j}, {held_i, held_j});
      check("stall_last", out_last, held_l);
    end
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_beat", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("beat_data", out_data, e.d);
        check("beat_i", 32'(out_i), 32'(e.i));
        check("beat_j", 32'(out_j), 32'(e.j));
        check("beat_last", out_last, e.last);
      end
    end
    stall_prev = out_valid && !out_ready;
    held_d = out_data;
    held_i = out_i;
    held_j = out_j;
    held_l = out_last;
  end

  task automatic push_drain(input int count);
    int i, j;
    beat_t b;
    for (int k = 0; k < count; k++) begin
`ifdef COLLECTOR_TRANSPOSE_EN
      i = k % 4;
      j = k / 4;
`else
      i = k / 4;
      j = k % 4;
`endif
      b.d    = mdl_wr[i*4+j] ? mdl_mem[i*4+j] : 32'd0;
      b.i    = i;
      b.j    = j;
      b.last = (i == 3) && (j == 3);
      sb_q.push_back(b);
    end
  endtask

  task automatic wr(input int i, input int j, input logic [31:0] v);
    bit got = 1'b0;
    z_i = 2'(i);
    z_j = 2'(j);
    z_out = v;
    z_stb = 1'b1;
    for (int c = 0; c < 8 && !got; c++) begin
      tick();
      if (z_ack) got = 1'b1;
    end
    z_stb = 1'b0;
    check("write_ack", got, 1'b1);
    mdl_mem[i*4+j] = v;
    mdl_wr[i*4+j] = 1'b1;
    tick();
  endtask

  task automatic do_clear();
    mult_done = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int k = 0; k < 16; k++) mdl_wr[k] = 1'b0;
  endtask

  task automatic fill();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        wr(i, j, 32'(i*4 + j));
  endtask

  task automatic run_drain(input bit toggle, input bit exp_incomplete);
    bit seen_done = 1'b0;
    push_drain(16);
    mult_done = 1'b1;
    out_ready = 1'b1;
    tk = 0;
    toggle_en = toggle;
    for (int c = 0; c < 200 && !seen_done; c++) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    toggle_en = 1'b0;
    out_ready = 1'b0;
    check("drain_done", done, 1'b1);
    check("done_valid_low", out_valid, 1'b0);
    check("drain_incomplete", incomplete, exp_incomplete);
    check("drain_left", sb_q.size(), 32'd0);
  endtask

  initial begin
    int a0;
    rst = 1'b1; clear = 1'b0; z_stb = 1'b0; mult_done = 1'b0; out_ready = 1'b0;
    z_out = '0; z_i = '0; z_j = '0;
    for (int k = 0; k < 16; k++) begin mdl_wr[k] = 1'b0; mdl_mem[k] = '0; end
    repeat (3) @(posedge clk);
    #1;
    check("rst_z_ack", z_ack, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_flags", {incomplete, late_write}, 2'b00);
    check("rst_out", {out_data, out_i, out_j}, 36'd0);
    check("rst_current", current_element, 32'd0);
    rst = 1'b0;
    tick();

    // First write: read-before-edge is 0, ack pulses once, then value visible.
    z_i = 2'd1; z_j = 2'd2; z_out = 32'd5; z_stb = 1'b1;
    #1;
    check("pre_write_current", current_element, 32'd0);
    tick();
    check("first_ack", z_ack, 1'b1);
    check("first_current", current_element, 32'd5);
    z_stb = 1'b0;
    tick();
    check("ack_one_cycle", z_ack, 1'b0);

    // Accumulation on [0][0].
    do_clear();
    a0 = ack_cnt;
    wr(0, 0, 32'd3);
    wr(0, 0, 32'd7);
    check("accum_acks", ack_cnt - a0, 32'd2);
    z_i = 2'd0; z_j = 2'd0;
    #1;
    check("accum_current", current_element, 32'd7);
    z_j = 2'd1;
    #1;
    check("accum_other_zero", current_element, 32'd0);

    // z_stb held high 3 edges: accepted on edges 1 and 3 only.
    a0 = ack_cnt;
    z_i = 2'd2; z_j = 2'd2; z_out = 32'd11; z_stb = 1'b1;
    repeat (3) tick();
    z_stb = 1'b0;
    tick();
    check("held_stb_acks", ack_cnt - a0, 32'd2);

    // Full fill, full-rate drain.
    do_clear();
    fill();
    run_drain(1'b0, 1'b0);

    // Full fill, stalling consumer.
    do_clear();
    fill();
    run_drain(1'b1, 1'b0);

    // Sparse: only [3][3].
    do_clear();
    wr(3, 3, 32'd9);
    run_drain(1'b0, 1'b1);

    // Late write and clear mid-drain.
    do_clear();
    wr(1, 1, 32'd4);
    mult_done = 1'b1;
    tick();
    check("mid_valid", out_valid, 1'b1);
    check("mid_incomplete", incomplete, 1'b1);
    z_i = 2'd0; z_j = 2'd0; z_out = 32'd1; z_stb = 1'b1;
    tick();
    check("late_no_ack0", z_ack, 1'b0);
    tick();
    check("late_no_ack1", z_ack, 1'b0);
    check("late_flag", late_write, 1'b1);
    z_stb = 1'b0;
    push_drain(3);
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    check("partial_left", sb_q.size(), 32'd0);
    mult_done = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int k = 0; k < 16; k++) mdl_wr[k] = 1'b0;
    check("clr_valid", out_valid, 1'b0);
    check("clr_last", out_last, 1'b0);
    check("clr_flags", {done, incomplete, late_write}, 3'b000);
    for (int k = 0; k < 16; k++) begin
      z_i = 2'(k / 4); z_j = 2'(k % 4);
      #1;
      check("clr_current", current_element, 32'd0);
    end

    // Async reset mid-drain.
    wr(2, 3, 32'd6);
    mult_done = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    check("rst_mid_valid", out_valid, 1'b0);
    check("rst_mid_flags", {done, incomplete, late_write}, 3'b000);
    mult_done = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/result_matrix_collector.md
Name: result_matrix_collector

Overview:
Downstream stage of sequential_matrix_multiplier. Accepts result elements over the z_stb/z_ack handshake and stores them in an internal N×N buffer. Feeds the currently stored value of the addressed element back to the multiplier as current_element, so the multiplier can accumulate partial sums. When the multiplier signals done, the block drains the buffer row-major over a valid/ready stream toward the output writer.

Parameters:
N, 4, matrix dimension (square N×N result)
W, 32, element width in bits
IDX_W, $clog2(N), row/column index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
clear  in  1  synchronous restart: empty the buffer and return to COLLECT
z_stb  in  1  multiplier has a result element
z_out  in  W  result value
z_i  in  IDX_W  result row
z_j  in  IDX_W  result column
z_ack  out  1  one-cycle acceptance pulse
current_element  out  W  stored value at [z_i][z_j], or 0 if not yet written
mult_done  in  1  multiplier finished all elements
out_valid  out  1  drain element valid
out_ready  in  1  consumer accepts the element
out_data  out  W  drain element value
out_i  out  IDX_W  drain row
out_j  out  IDX_W  drain column
out_last  out  1  final drain element (index N-1,N-1)
done  out  1  drain complete; held until clear
incomplete  out  1  sticky: drain started with at least one element never written
late_write  out  1  sticky: z_stb seen while in DRAIN or DONE

Behaviour:
- Reset (async) values:
  - z_ack=0, out_valid=0, out_last=0, done=0, incomplete=0, late_write=0.
  - out_data=0, out_i=0, out_j=0.
  - Written bitmap (N*N bits) all 0; state=COLLECT; drain counters 0.
  - Buffer contents are not reset; the bitmap masks them.
- current_element is combinational: written[z_i][z_j] ? mem[z_i][z_j] : 0. It is valid in every state.
- States: COLLECT, DRAIN, DONE.
- COLLECT:
  - Accept when z_stb=1 and z_ack=0. On that edge: mem[z_i][z_j]<=z_out, written bit set, z_ack<=1.
  - z_ack is high for exactly one cycle. z_stb held high across the ack cycle is not accepted twice; the next acceptance happens no earlier than 2 cycles later.
  - Rewriting the same index overwrites it. This is normal accumulation, not an error.
- COLLECT -> DRAIN: when mult_done=1 and no acceptance occurs on that edge. If mult_done and an acceptance coincide, the acceptance wins and the transition happens on the next edge.
  - On entry: incomplete<=~&written; drain index set to (0,0).
- DRAIN:
  - out_valid=1. out_data, out_i, out_j are registered from the current drain index. The read of element k+1 is prefetched so a full-rate out_ready gives 1 element per cycle.
  - Index advances only on out_valid&&out_ready. j wraps N-1 -> 0 and increments i.
  - Data and index are held stable while out_ready=0.
  - out_last=1 only on (N-1,N-1).
  - Unwritten elements drain as 0.
- DRAIN -> DONE: on the handshake of the last element. out_valid<=0 and done<=1 on the same edge.
- DONE: holds until clear. In DRAIN and DONE, z_stb is never acked and sets late_write.
- clear: synchronous. Has priority over everything except rst. It empties the bitmap, drops out_valid, and clears done, incomplete and late_write. Any in-progress drain is aborted; no partial out_last is produced.
- rst mid-drain: immediate abort to reset values.

Optional Feature:
COLLECTOR_TRANSPOSE_EN
- Defined: drain order is column-major. j is the outer index and i the inner, so the stream emits R transposed while out_i/out_j still report true coordinates. out_last is still (N-1,N-1).
- Undefined: row-major as specified above.
- Collection behaviour is identical either way.

Decomposition:
- Shared package matrix_pkg holds:
  - Localparams: W default 32 and a function idx_width(N).
  - Typedef for the state enum (COLLECT, DRAIN, DONE).
  - Typedef for an index pair struct {i,j}.
- One natural sub-module, matrix_index_counter: a 2-D wrapping counter with an advance input, a major-order select, and a last flag. It is reused by the drain logic and the writer.

Test Plan:
- After reset, z_stb with z_i=1, z_j=2, z_out=5 -> current_element reads 0 before the edge; z_ack pulses one cycle; then current_element=5.
- Accumulate [0][0]: 3, then 3+4 fed back as 7 -> exactly two acks; current_element=7; bitmap count=1.
- Fill all 16 elements with value i*4+j, raise mult_done, out_ready=1 -> 16 consecutive beats 0..15 in row-major order; out_last on the 16th; done=1 the next cycle; incomplete=0.
- Same as above with out_ready toggling 1,0,0,1 -> no duplicated or skipped elements; data held stable during stalls.
- Write only [3][3]=9, then mult_done -> incomplete=1; 15 zeros followed by 9; out_last on the 9.
- During drain, assert z_stb -> no z_ack; late_write=1. Assert clear mid-drain -> out_valid=0 next cycle; flags cleared; current_element=0 for all indices.
